// File: rtl/pcap_record_parser.sv
// pcap_record_parser: strips the pcap global header, parses each record header and
// re-emits the packet payload as beat-aligned stream data with per-packet metadata.
module pcap_record_parser #(
   parameter int MAX_LEN = 9600,
   parameter int LEN_W   = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             PCAP_TVALID,
   output logic             PCAP_TREADY,
   input  logic [127:0]     PCAP_TDATA,
   output logic             M_TVALID,
   input  logic             M_TREADY,
   output logic [127:0]     M_TDATA,
   output logic [15:0]      M_TKEEP,
   output logic             M_TLAST,
   output logic [LEN_W-1:0] PKT_LEN,
   output logic [31:0]      TS_SEC,
   output logic [31:0]      TS_USEC,
   output logic             NSEC_MODE,
   output logic [31:0]      PKT_COUNT,
   output logic             ERR
);

   localparam int REM_W = $clog2(MAX_LEN + 1);
   localparam logic [31:0] MAGIC_USEC = 32'hA1B2C3D4;
   localparam logic [31:0] MAGIC_NSEC = 32'hA1B23C4D;

   typedef enum logic [1:0] {
      ST_GHDR  = 2'd0,
      ST_RHDR  = 2'd1,
      ST_DATA  = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [255:0]       buf_r;
   logic [5:0]         cnt_r;
   logic [REM_W-1:0]   rem_r;
   logic               out_valid_r;
   logic [127:0]       out_data_r;
   logic [15:0]        out_keep_r;
   logic               out_last_r;
   logic [LEN_W-1:0]   pkt_len_r;
   logic [31:0]        ts_sec_r;
   logic [31:0]        ts_usec_r;
   logic               nsec_r;
   logic [31:0]        pkt_count_r;
   logic               err_r;

   logic               tready_s;
   logic               accept_s;
   logic               append_s;
   logic               drain_s;
   logic               can_load_s;
   logic [31:0]        magic_s;
   logic [31:0]        hdr_sec_s;
   logic [31:0]        hdr_usec_s;
   logic [31:0]        hdr_len_s;
   logic [4:0]         dat_n_s;
   logic [15:0]        dat_keep_s;
   logic               dat_last_s;
   logic [5:0]         consume_s;
   logic               set_nsec_s;
   logic               nsec_val_s;
   logic               ts_load_s;
   logic               hdr_load_s;
   logic               data_fire_s;
   logic [255:0]       shifted_s;
   logic [255:0]       buf_nxt_s;
   logic [5:0]         cnt_nxt_s;

   // Expands contiguous byte enables into a bit mask so unused lanes are zeroed.
   function automatic logic [127:0] keep_to_mask(input logic [15:0] keep);
      logic [127:0] mask;
      mask = 128'd0;
      for (int i = 0; i < 16; i++) begin
         mask[8*i +: 8] = {8{keep[i]}};
      end
      return mask;
   endfunction

   assign tready_s   = (state_r == ST_ERROR) ? 1'b1 : (cnt_r <= 6'd16);
   assign accept_s   = PCAP_TVALID && tready_s;
   assign append_s   = accept_s && (state_r != ST_ERROR);
   assign drain_s    = out_valid_r && M_TREADY;
   assign can_load_s = !out_valid_r || M_TREADY;

   assign magic_s    = buf_r[31:0];
   assign hdr_sec_s  = buf_r[31:0];
   assign hdr_usec_s = buf_r[63:32];
   assign hdr_len_s  = buf_r[95:64];

   assign dat_n_s    = (rem_r >= REM_W'(32'd16)) ? 5'd16 : 5'(rem_r);
   assign dat_keep_s = 16'((32'd1 << dat_n_s) - 32'd1);
   assign dat_last_s = (rem_r == REM_W'(dat_n_s));

   // Next-state and consume decisions for the parser FSM.
   always_comb begin
      state_nxt_s = state_r;
      consume_s   = 6'd0;
      set_nsec_s  = 1'b0;
      nsec_val_s  = 1'b0;
      ts_load_s   = 1'b0;
      hdr_load_s  = 1'b0;
      data_fire_s = 1'b0;
      case (state_r)
         ST_GHDR: begin
            if (cnt_r >= 6'd24) begin
               if (magic_s == MAGIC_USEC) begin
                  consume_s   = 6'd24;
                  set_nsec_s  = 1'b1;
                  nsec_val_s  = 1'b0;
                  state_nxt_s = ST_RHDR;
               end else if (magic_s == MAGIC_NSEC) begin
                  consume_s   = 6'd24;
                  set_nsec_s  = 1'b1;
                  nsec_val_s  = 1'b1;
                  state_nxt_s = ST_RHDR;
               end else begin
                  state_nxt_s = ST_ERROR;
               end
            end else begin
               state_nxt_s = ST_GHDR;
            end
         end
         ST_RHDR: begin
            // Metadata must not move while a beat of the previous packet is still held.
            if ((cnt_r >= 6'd16) && can_load_s) begin
               consume_s = 6'd16;
               if (hdr_len_s > 32'(MAX_LEN)) begin
                  state_nxt_s = ST_ERROR;
               end else if (hdr_len_s == 32'd0) begin
                  ts_load_s   = 1'b1;
                  state_nxt_s = ST_RHDR;
               end else begin
                  ts_load_s   = 1'b1;
                  hdr_load_s  = 1'b1;
                  state_nxt_s = ST_DATA;
               end
            end else begin
               state_nxt_s = ST_RHDR;
            end
         end
         ST_DATA: begin
            if ((cnt_r >= 6'(dat_n_s)) && can_load_s) begin
               data_fire_s = 1'b1;
               consume_s   = 6'(dat_n_s);
               if (dat_last_s) begin
                  state_nxt_s = ST_RHDR;
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_ERROR: begin
            state_nxt_s = ST_ERROR;
         end
         default: begin
            state_nxt_s = ST_GHDR;
         end
      endcase
   end

   // New bytes always land directly above whatever survives this cycle's consume.
   always_comb begin
      shifted_s = buf_r >> {consume_s, 3'b000};
      if (append_s) begin
         buf_nxt_s = shifted_s | ({128'd0, PCAP_TDATA} << {cnt_r - consume_s, 3'b000});
         cnt_nxt_s = cnt_r - consume_s + 6'd16;
      end else begin
         buf_nxt_s = shifted_s;
         cnt_nxt_s = cnt_r - consume_s;
      end
   end

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_GHDR;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Holding buffer, packet bookkeeping and the registered output stage.
   always_ff @(posedge CLK) begin
      if (RST) begin
         buf_r       <= 256'd0;
         cnt_r       <= 6'd0;
         rem_r       <= '0;
         out_valid_r <= 1'b0;
         out_data_r  <= 128'd0;
         out_keep_r  <= 16'd0;
         out_last_r  <= 1'b0;
         pkt_len_r   <= '0;
         ts_sec_r    <= 32'd0;
         ts_usec_r   <= 32'd0;
         nsec_r      <= 1'b0;
         pkt_count_r <= 32'd0;
         err_r       <= 1'b0;
      end else begin
         buf_r <= buf_nxt_s;
         cnt_r <= cnt_nxt_s;
         if (set_nsec_s) begin
            nsec_r <= nsec_val_s;
         end
         if (ts_load_s) begin
            ts_sec_r  <= hdr_sec_s;
            ts_usec_r <= hdr_usec_s;
         end
         if (hdr_load_s) begin
            pkt_len_r <= hdr_len_s[LEN_W-1:0];
            rem_r     <= hdr_len_s[REM_W-1:0];
         end else if (data_fire_s) begin
            rem_r <= rem_r - REM_W'(dat_n_s);
         end
         if (data_fire_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= buf_r[127:0] & keep_to_mask(dat_keep_s);
            out_keep_r  <= dat_keep_s;
            out_last_r  <= dat_last_s;
         end else if (drain_s) begin
            out_valid_r <= 1'b0;
         end
         if (data_fire_s && dat_last_s) begin
            pkt_count_r <= pkt_count_r + 32'd1;
         end
         if (state_nxt_s == ST_ERROR) begin
            err_r <= 1'b1;
         end
      end
   end

   assign PCAP_TREADY = tready_s;
   assign M_TVALID    = out_valid_r;
   assign M_TDATA     = out_data_r;
   assign M_TKEEP     = out_keep_r;
   assign M_TLAST     = out_last_r;
   assign PKT_LEN     = pkt_len_r;
   assign TS_SEC      = ts_sec_r;
   assign TS_USEC     = ts_usec_r;
   assign NSEC_MODE   = nsec_r;
   assign PKT_COUNT   = pkt_count_r;
   assign ERR         = err_r;

endmodule

// File: tb/tb_pcap_record_parser.sv
// Self-checking bench for pcap_record_parser: builds pcap byte streams, predicts the
// output beats into a scoreboard queue and compares them as the DUT emits them.
module tb_pcap_record_parser;

   localparam int MAX_LEN = 9600;
   localparam int LEN_W   = 16;

   logic             CLK = 1'b0;
   logic             RST;
   logic             PCAP_TVALID;
   logic             PCAP_TREADY;
   logic [127:0]     PCAP_TDATA;
   logic             M_TVALID;
   logic             M_TREADY;
   logic [127:0]     M_TDATA;
   logic [15:0]      M_TKEEP;
   logic             M_TLAST;
   logic [LEN_W-1:0] PKT_LEN;
   logic [31:0]      TS_SEC;
   logic [31:0]      TS_USEC;
   logic             NSEC_MODE;
   logic [31:0]      PKT_COUNT;
   logic             ERR;

   pcap_record_parser #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .CLK(CLK), .RST(RST),
      .PCAP_TVALID(PCAP_TVALID), .PCAP_TREADY(PCAP_TREADY), .PCAP_TDATA(PCAP_TDATA),
      .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA),
      .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST), .PKT_LEN(PKT_LEN),
      .TS_SEC(TS_SEC), .TS_USEC(TS_USEC), .NSEC_MODE(NSEC_MODE),
      .PKT_COUNT(PKT_COUNT), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [127:0] data;
      logic [15:0]  keep;
      logic         last;
      logic [15:0]  pkt_len;
      logic [31:0]  ts_sec;
   } beat_t;

   typedef struct {
      logic [31:0] magic;
      int          ready_mode;
      int          nrec;
      int          len0;
      int          len1;
      int          len2;
      int          exp_beats;
      logic [31:0] exp_count;
      logic        exp_nsec;
      logic        exp_err;
      logic [15:0] exp_pkt_len;
      logic [15:0] exp_last_keep;
      logic        err_lat_chk;
   } scen_t;

   logic [7:0]   stream [$];
   beat_t        exp_q [$];
   scen_t        scen [6];
   int           pos;
   int           checks;
   int           fails;
   int           cyc;
   int           beats_seen;
   int           first_acc;
   int           err_cyc;
   int           ready_mode;
   logic         prev_stall;
   logic [145:0] prev_out;
   logic [15:0]  last_keep;
   logic [3:0]   ready_pat;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic add_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) stream.push_back(w[8*i +: 8]);
   endtask

   task automatic add_ghdr(input logic [31:0] magic);
      add_word(magic);
      add_word(32'h00040002);
      add_word(32'h0);
      add_word(32'h0);
      add_word(32'h0000FFFF);
      add_word(32'h1);
   endtask

   task automatic add_record(input logic [31:0] sec, input logic [31:0] usec,
                             input int len, input int tag, input bit expect_out);
      beat_t b;
      add_word(sec);
      add_word(usec);
      add_word(32'(len));
      add_word(32'(len));
      for (int j = 0; j < len; j++) stream.push_back(8'(j + 64 * tag));
      if (expect_out) begin
         for (int off = 0; off < len; off += 16) begin
            b.data = 128'd0;
            b.keep = 16'd0;
            for (int i = 0; i < 16; i++) begin
               if (off + i < len) begin
                  b.data[8*i +: 8] = 8'(off + i + 64 * tag);
                  b.keep[i] = 1'b1;
               end
            end
            b.last    = (off + 16 >= len);
            b.pkt_len = 16'(len);
            b.ts_sec  = sec;
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic pad_stream();
      while ((stream.size() % 16) != 0) stream.push_back(8'h00);
   endtask

   task automatic drive_inputs();
      if (pos < stream.size()) begin
         PCAP_TVALID = 1'b1;
         for (int i = 0; i < 16; i++) PCAP_TDATA[8*i +: 8] = stream[pos + i];
      end else begin
         PCAP_TVALID = 1'b0;
         PCAP_TDATA  = 128'd0;
      end
      M_TREADY = (ready_mode == 0) ? 1'b1 : ready_pat[cyc % 4];
   endtask

   // One clock: sample and score at the falling edge, advance stimulus after the rising edge.
   task automatic cycle();
      logic  in_acc;
      beat_t e;
      @(negedge CLK);
      in_acc = PCAP_TVALID && PCAP_TREADY;
      if (in_acc && first_acc < 0) first_acc = cyc;
      if (ERR && err_cyc < 0) err_cyc = cyc;
      if (ERR) chk("tready_in_error", 160'(PCAP_TREADY), 160'(1'b1));
      if (prev_stall)
         chk("stall_hold", 160'({M_TVALID, M_TLAST, M_TKEEP, M_TDATA}), 160'(prev_out));
      if (M_TVALID && M_TREADY) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_beat actual data=%h keep=%h last=%b expected no beat",
                     M_TDATA, M_TKEEP, M_TLAST);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", 160'(M_TDATA), 160'(e.data));
            chk("beat_keep", 160'(M_TKEEP), 160'(e.keep));
            chk("beat_last", 160'(M_TLAST), 160'(e.last));
            chk("beat_pkt_len", 160'(PKT_LEN), 160'(e.pkt_len));
            chk("beat_ts_sec", 160'(TS_SEC), 160'(e.ts_sec));
         end
         beats_seen++;
         if (M_TLAST) last_keep = M_TKEEP;
      end
      prev_stall = M_TVALID && !M_TREADY;
      prev_out   = {M_TVALID, M_TLAST, M_TKEEP, M_TDATA};
      @(posedge CLK);
      #1;
      if (in_acc) pos += 16;
      cyc++;
      drive_inputs();
   endtask

   task automatic run(input int stop_beats);
      int budget;
      int idle;
      budget = 30000;
      idle   = 0;
      while (budget > 0) begin
         cycle();
         budget--;
         if (stop_beats > 0 && beats_seen >= stop_beats) break;
         if (pos >= stream.size() && exp_q.size() == 0) begin
            idle++;
            if (idle >= 8) break;
         end
      end
      if (budget == 0) begin
         checks++;
         fails++;
         $display("FAIL run_timeout actual=%0d beats pending expected 0 within budget", exp_q.size());
      end
   endtask

   // One-cycle reset pulse followed by the all-zero output check.
   task automatic do_reset();
      RST         = 1'b1;
      PCAP_TVALID = 1'b0;
      PCAP_TDATA  = 128'd0;
      M_TREADY    = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("reset_stream_out", 160'({M_TVALID, M_TLAST, M_TKEEP, M_TDATA}), 160'd0);
      chk("reset_metadata", 160'({PKT_LEN, TS_SEC, TS_USEC, NSEC_MODE, PKT_COUNT, ERR}), 160'd0);
      chk("reset_tready", 160'(PCAP_TREADY), 160'(1'b1));
      stream.delete();
      exp_q.delete();
      pos        = 0;
      cyc        = 0;
      beats_seen = 0;
      first_acc  = -1;
      err_cyc    = -1;
      prev_stall = 1'b0;
      last_keep  = 16'd0;
   endtask

   initial begin
      scen_t sc;
      int    lens [3];
      checks      = 0;
      fails       = 0;
      ready_pat   = 4'b1001;
      ready_mode  = 0;
      RST         = 1'b1;
      PCAP_TVALID = 1'b0;
      PCAP_TDATA  = 128'd0;
      M_TREADY    = 1'b1;

      //        magic          rdy nrec len0  len1 len2 beats cnt    nsec  err   pkt_len  last_keep lat
      scen[0] = '{32'hA1B2C3D4, 0, 1, 60,   0,   0,   4,   32'd1, 1'b0, 1'b0, 16'd60,   16'h0FFF, 1'b0};
      scen[1] = '{32'hA1B23C4D, 0, 3, 1,    17,  0,   3,   32'd2, 1'b1, 1'b0, 16'd17,   16'h0001, 1'b0};
      scen[2] = '{32'hA1B2C3D4, 1, 1, 60,   0,   0,   4,   32'd1, 1'b0, 1'b0, 16'd60,   16'h0FFF, 1'b0};
      scen[3] = '{32'hD4C3B2A1, 0, 1, 60,   0,   0,   0,   32'd0, 1'b0, 1'b1, 16'd0,    16'h0000, 1'b1};
      scen[4] = '{32'hA1B2C3D4, 0, 1, 9601, 0,   0,   0,   32'd0, 1'b0, 1'b1, 16'd0,    16'h0000, 1'b0};
      scen[5] = '{32'hA1B2C3D4, 0, 1, 9600, 0,   0,   600, 32'd1, 1'b0, 1'b0, 16'd9600, 16'hFFFF, 1'b0};

      for (int s = 0; s < 6; s++) begin
         sc = scen[s];
         do_reset();
         ready_mode = sc.ready_mode;
         lens[0] = sc.len0;
         lens[1] = sc.len1;
         lens[2] = sc.len2;
         add_ghdr(sc.magic);
         for (int r = 0; r < sc.nrec; r++)
            add_record(32'h11223344, 32'h00000055, lens[r], r, !sc.exp_err);
         pad_stream();
         run(0);
         chk("beat_count", 160'(beats_seen), 160'(sc.exp_beats));
         chk("leftover_beats", 160'(exp_q.size()), 160'd0);
         chk("pkt_count", 160'(PKT_COUNT), 160'(sc.exp_count));
         chk("nsec_mode", 160'(NSEC_MODE), 160'(sc.exp_nsec));
         chk("err", 160'(ERR), 160'(sc.exp_err));
         chk("pkt_len", 160'(PKT_LEN), 160'(sc.exp_pkt_len));
         if (!sc.exp_err) begin
            chk("ts_sec", 160'(TS_SEC), 160'(32'h11223344));
            chk("ts_usec", 160'(TS_USEC), 160'(32'h00000055));
            chk("last_keep", 160'(last_keep), 160'(sc.exp_last_keep));
         end
         if (sc.err_lat_chk)
            chk("err_latency", 160'((err_cyc >= 0) && (err_cyc - first_acc <= 3)), 160'(1'b1));
      end

      // Reset in the middle of a packet, then a fresh nanosecond trace.
      do_reset();
      ready_mode = 0;
      add_ghdr(32'hA1B2C3D4);
      add_record(32'hAABBCCDD, 32'h00000001, 60, 0, 1'b1);
      pad_stream();
      run(2);
      chk("midpkt_beats_before_reset", 160'(beats_seen), 160'd2);
      do_reset();
      add_ghdr(32'hA1B23C4D);
      add_record(32'h01020304, 32'h00000005, 20, 1, 1'b1);
      pad_stream();
      run(0);
      chk("fresh_beat_count", 160'(beats_seen), 160'd2);
      chk("fresh_pkt_count", 160'(PKT_COUNT), 160'd1);
      chk("fresh_ts_sec", 160'(TS_SEC), 160'(32'h01020304));
      chk("fresh_pkt_len", 160'(PKT_LEN), 160'd20);
      chk("fresh_nsec", 160'(NSEC_MODE), 160'(1'b1));
      chk("fresh_err", 160'(ERR), 160'(1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/pcap_record_parser.md
Name: pcap_record_parser

Overview:
- Sits directly upstream of pcap2hwgen, between the raw pcap byte source and the generator.
- Takes the raw pcap file as a 128-bit byte stream, with byte 0 in [7:0]. Checks and discards the 24-byte global header.
- Parses each 16-byte record header, then emits the packet bytes realigned to beat boundaries with TKEEP/TLAST, plus per-packet metadata.
- Detects malformed traces and flags them sticky.

Parameters:
- MAX_LEN, 9600: largest legal incl_len in bytes; anything larger is a format error.
- LEN_W, 16: width of the PKT_LEN output.

Ports:
- CLK  in  1  clock, all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- PCAP_TVALID  in  1  input beat valid.
- PCAP_TREADY  out  1  input beat accepted when TVALID&&TREADY.
- PCAP_TDATA  in  128  16 raw file bytes; byte i in [8i+7:8i].
- M_TVALID  out  1  output beat valid.
- M_TREADY  in  1  downstream ready.
- M_TDATA  out  128  packet bytes; first packet byte of each beat in [7:0].
- M_TKEEP  out  16  byte enables, contiguous from bit 0.
- M_TLAST  out  1  last beat of the packet.
- PKT_LEN  out  LEN_W  incl_len of the current packet.
- TS_SEC  out  32  ts_sec of the current packet.
- TS_USEC  out  32  ts_usec (or ts_nsec) of the current packet.
- NSEC_MODE  out  1  1 if the global magic was the nanosecond variant.
- PKT_COUNT  out  32  packets fully emitted; wraps at 2^32.
- ERR  out  1  sticky format error.

Behaviour:
- Reset: all outputs 0, holding buffer count 0, state GHDR. Reset applies immediately in any state, including mid-packet; partial data is discarded.
- Holding buffer: 32 bytes, count CNT in 0..32.
- PCAP_TREADY = (CNT<=16) in GHDR/RHDR/DATA; PCAP_TREADY = 1 in ERROR.
- An accepted beat appends 16 bytes after the existing CNT bytes.
- Consuming n bytes shifts the buffer down by n.
- Accept and consume may occur in the same cycle: CNT_next = CNT - n + 16·accept.
- States:
  - GHDR: wait for CNT>=24.
    - Bytes 0..3 == D4 C3 B2 A1 sets NSEC_MODE=0; == 4D 3C B2 A1 sets NSEC_MODE=1.
    - On a match, consume 24 and go to RHDR. Any other value goes to ERROR (big-endian traces are unsupported).
  - RHDR: wait for CNT>=16, then consume 16.
    - Latch TS_SEC = bytes 0..3, TS_USEC = bytes 4..7, incl_len = bytes 8..11, all little-endian. orig_len is ignored.
    - incl_len > MAX_LEN goes to ERROR.
    - incl_len == 0: no output beat, PKT_COUNT unchanged, stay in RHDR.
    - Otherwise PKT_LEN = incl_len[LEN_W-1:0], REM = incl_len, go to DATA.
  - DATA: n = min(REM,16).
    - Fires when CNT>=n and the output register is empty or being drained (M_TREADY&&M_TVALID).
    - Loads M_TDATA = buffer bytes 0..n-1 with unused bytes zeroed, M_TKEEP = (1<<n)-1, M_TLAST = (REM==n). Then REM -= n.
    - When REM reaches 0, go to RHDR and increment PKT_COUNT in the cycle the TLAST beat is loaded.
  - ERROR: ERR=1, all input accepted and dropped, M_TVALID=0 once the output register drains. Only RST exits.
- Output register:
  - M_* are registered and held stable while M_TVALID && !M_TREADY.
  - PKT_LEN, TS_SEC and TS_USEC change only in RHDR, and never while a beat of the previous packet is pending.
- Latency: a DATA beat appears on M_TVALID one cycle after its bytes are in the buffer and the fire condition holds. Sustained throughput is 1 beat/cycle when the input is always valid and the output always ready.
- Header fields may straddle input beats at any alignment, and packet end need not be beat-aligned; the buffer handles both.
- Trailing bytes after the last complete record are held in the buffer and never emitted.

Test Plan:
- Global header D4C3B2A1 plus a record with ts_sec=0x11223344, ts_usec=0x55, incl_len=60 and bytes 00..3B; output always ready.
  -> 4 beats with TKEEP FFFF, FFFF, FFFF, 0FFF; TLAST only on beat 4; beat 1 [7:0]=00; TS_SEC=11223344, PKT_LEN=60, PKT_COUNT=1, NSEC_MODE=0, ERR=0.
- Back-to-back records with incl_len 1, 17 and 0, nanosecond magic.
  -> beats (TKEEP 0001, TLAST), (FFFF), (0001, TLAST); PKT_COUNT=2; NSEC_MODE=1.
- Same traffic as the first scenario with M_TREADY toggled 1,0,0,1 repeating.
  -> identical beat sequence; no beat lost or duplicated; M_* stable while stalled.
- Magic A1B2C3D4 (big-endian).
  -> ERR=1 within 2 cycles of the first beat; PCAP_TREADY=1 thereafter; M_TVALID never asserts; subsequent RST clears ERR.
- Record with incl_len=MAX_LEN+1=9601.
  -> ERR=1, no data beats; incl_len=9600 in a separate run gives 600 beats with the last beat TKEEP=FFFF.
- RST asserted for 1 cycle after beat 2 of a 60-byte packet, followed by a fresh trace.
  -> all outputs 0 in the next cycle; the fresh trace parses correctly with PKT_COUNT restarting at 1.
